// File: rtl/md4_msg_padder.sv
// MD4 message padder: packs a byte stream into 512-bit blocks and appends
// 0x80, zero fill and the 64-bit little-endian bit length.
module md4_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_final
);

  typedef enum logic [1:0] {FILL, HOLD, HOLD_X} state_e;

  state_e             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [6:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               pend_q, pend_d;
  logic               x80_q, x80_d;
  logic               ofirst_q, ofirst_d;
  logic               ofinal_q, ofinal_d;

  logic               accept, wr_data, last_beat, blk_full;
  logic [6:0]         pos;
  logic [CNT_W-1:0]   cnt_inc;
  logic [63:0]        len_new, len_cur;

  assign accept    = in_valid & in_ready;
  assign wr_data   = accept & ~(in_last & in_empty);
  assign last_beat = accept & in_last;
  assign blk_full  = wr_data & ~in_last & (idx_q == 7'd63);
  assign pos       = idx_q + 7'(wr_data);
  // The length must include a byte written in the same cycle as in_last.
  assign cnt_inc   = cnt_q + CNT_W'(wr_data);
  assign len_new   = 64'({cnt_inc, 3'b000});
  assign len_cur   = 64'({cnt_q, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_beat || blk_full) state_d = HOLD;
      HOLD:    if (out_ready) state_d = pend_q ? HOLD_X : FILL;
      HOLD_X:  if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL) && !rst;
    out_valid = (state_q != FILL);
    out_block = blk_q;
    out_first = ofirst_q;
    out_final = ofinal_q;
  end

  always_comb begin
    blk_d    = blk_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    pend_d   = pend_q;
    x80_d    = x80_q;
    ofirst_d = ofirst_q;
    ofinal_d = ofinal_q;
    case (state_q)
      FILL: begin
        for (int i = 0; i < 64; i++) begin
          if (wr_data && (7'(i) == idx_q)) blk_d[8*i +: 8] = in_data;
          if (last_beat) begin
            if (7'(i) == pos)                 blk_d[8*i +: 8] = 8'h80;
            else if ((7'(i) > pos) && i < 56) blk_d[8*i +: 8] = 8'h00;
            if ((pos <= 7'd55) && i >= 56)    blk_d[8*i +: 8] = len_new[8*(i-56) +: 8];
          end
        end
        idx_d = pos;
        cnt_d = cnt_inc;
        if (last_beat) begin
          ofirst_d = first_q;
          if (pos <= 7'd55) begin
            ofinal_d = 1'b1;
            pend_d   = 1'b0;
          end else begin
            ofinal_d = 1'b0;
            pend_d   = 1'b1;
            x80_d    = (pos == 7'd64);
          end
        end else if (blk_full) begin
          ofirst_d = first_q;
          ofinal_d = 1'b0;
        end
      end
      HOLD: if (out_ready) begin
        if (pend_q) begin
          blk_d    = {len_cur, 440'd0, (x80_q ? 8'h80 : 8'h00)};
          ofinal_d = 1'b1;
          ofirst_d = 1'b0;
          first_d  = 1'b0;
        end else begin
          // A completed message re-arms first; a mid-message block clears it.
          if (ofinal_q) cnt_d = '0;
          first_d = ofinal_q;
          blk_d   = '0;
          idx_d   = '0;
        end
      end
      HOLD_X: if (out_ready) begin
        blk_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
        first_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      x80_q    <= 1'b0;
      ofirst_q <= 1'b0;
      ofinal_q <= 1'b0;
    end else begin
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      x80_q    <= x80_d;
      ofirst_q <= ofirst_d;
      ofinal_q <= ofinal_d;
    end
  end

endmodule

// File: tb/tb_md4_msg_padder.sv
// Directed bench for md4_msg_padder: known messages with hand-computed blocks.
module tb_md4_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [7:0]   in_data;
  logic         in_last, in_empty;
  logic         out_valid, out_ready;
  logic [511:0] out_block;
  logic         out_first, out_final;

  int compared   = 0;
  int mismatched = 0;

  logic [511:0] eAbc, eData56, eData64, eLen448, eX512;

  md4_msg_padder #(.CNT_W(61)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_first(out_first), .out_final(out_final)
  );

  always #5 clk = ~clk;

  // Comparisons are sampled 1ns after the rising edge.
  task automatic checkBlk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last, input logic empty);
    int w = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) checkBit("ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic sendRun(input int n, input logic lastOnEnd);
    for (int i = 0; i < n; i++) applyStimulus(8'(i), lastOnEnd && (i == n-1), 1'b0);
  endtask

  task automatic sendAbc();
    applyStimulus(8'h61, 1'b0, 1'b0);
    applyStimulus(8'h62, 1'b0, 1'b0);
    applyStimulus(8'h63, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] exp, input logic f, input logic fin);
    int w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk); #1; w++;
    end
    checkBit({tag, "_valid"}, out_valid, 1'b1);
    checkBlk({tag, "_block"}, out_block, exp);
    checkBit({tag, "_first"}, out_first, f);
    checkBit({tag, "_final"}, out_final, fin);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    eAbc = '0;  eAbc[31:0] = 32'h80636261;  eAbc[511:448] = 64'd24;
    eData56 = '0;
    for (int i = 0; i < 56; i++) eData56[8*i +: 8] = 8'(i);
    eData56[8*56 +: 8] = 8'h80;
    eData64 = '0;
    for (int i = 0; i < 64; i++) eData64[8*i +: 8] = 8'(i);
    eLen448 = '0; eLen448[511:448] = 64'd448;
    eX512 = '0;   eX512[7:0] = 8'h80;   eX512[511:448] = 64'd512;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkBit("rst_in_ready", in_ready, 1'b0);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkBlk("rst_out_block", out_block, 512'd0);
    checkBit("rst_out_first", out_first, 1'b0);
    checkBit("rst_out_final", out_final, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("post_rst_in_ready", in_ready, 1'b1);

    // Empty message
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkBit("empty_latency", out_valid, 1'b1);
    checkOutput("empty", 512'h80, 1'b1, 1'b1);
    checkBit("empty_back2back_ready", in_ready, 1'b1);

    // "abc"
    sendAbc();
    checkBit("abc_latency", out_valid, 1'b1);
    checkOutput("abc", eAbc, 1'b1, 1'b1);

    // "abc" under backpressure
    sendAbc();
    for (int c = 0; c < 5; c++) begin
      checkBlk("bp_block_stable", out_block, eAbc);
      checkBit("bp_in_ready", in_ready, 1'b0);
      checkBit("bp_valid_held", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    checkOutput("bp", eAbc, 1'b1, 1'b1);
    checkBit("bp_ready_after", in_ready, 1'b1);
    checkBit("bp_valid_after", out_valid, 1'b0);

    // 56-byte message spills the length into an extra block
    sendRun(56, 1'b1);
    checkOutput("m56_b1", eData56, 1'b1, 1'b0);
    checkBit("m56_extra_latency", out_valid, 1'b1);
    checkBit("m56_extra_no_input", in_ready, 1'b0);
    checkOutput("m56_b2", eLen448, 1'b0, 1'b1);

    // 64-byte message, last on the final data byte
    sendRun(64, 1'b1);
    checkOutput("m64_b1", eData64, 1'b1, 1'b0);
    checkOutput("m64_b2", eX512, 1'b0, 1'b1);

    // 64 data bytes then an empty last beat
    sendRun(64, 1'b0);
    checkOutput("m64e_b1", eData64, 1'b1, 1'b0);
    checkBit("m64e_back2back_ready", in_ready, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("m64e_b2", eX512, 1'b0, 1'b1);

    // Reset in the middle of a message
    sendRun(10, 1'b0);
    rst = 1'b1;
    #1;
    checkBit("midrst_in_ready", in_ready, 1'b0);
    checkBlk("midrst_block", out_block, 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sendAbc();
    checkBit("midrst_abc_latency", out_valid, 1'b1);
    checkOutput("midrst_abc", eAbc, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
